// File: rtl/ia_addr_sequencer.sv
// ---------------------------------------------------------------------------
// ia_addr_sequencer
// Control-side initiator for the IA address path. Walks the row/col address
// BRAMs in groups of four words, steers each word into arbiter lane 1..4, and
// then presents the assembled group downstream with a valid/ready handshake.
//
// Optional feature macro: IA_SEQ_ABORT_EN (adds the abort input).
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high
//   start            in   1-cycle pulse, begins a pass (ignored while busy)
//   num_groups       in   groups of 4 words to process, sampled on start
//   busy             out  high from accepted start until done
//   done             out  1-cycle pulse when the pass completes
//   addr_bram_enable out  BRAM enable (row and col BRAMs)
//   ram_address      out  BRAM read address
//   arbiter_ctrl     out  0 hold, 1..4 latch lane, 7 clear all lanes
//   group_valid      out  all four arbiter lanes hold the current group
//   group_ready      in   downstream accepts the group
//   abort            in   (IA_SEQ_ABORT_EN only) cancel the pass in flight
//   group_index      out  index of the presented group
// ---------------------------------------------------------------------------
module ia_addr_sequencer #(
  parameter int unsigned ram_address_width = 5,
  parameter int unsigned bram_latency      = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ram_address_width-2:0] num_groups,
  output logic                         busy,
  output logic                         done,
  output logic                         addr_bram_enable,
  output logic [ram_address_width-1:0] ram_address,
  output logic [2:0]                   arbiter_ctrl,
  output logic                         group_valid,
  input  logic                         group_ready,
`ifdef IA_SEQ_ABORT_EN
  input  logic                         abort,
`endif
  output logic [ram_address_width-3:0] group_index
);

  localparam int unsigned NG_W = ram_address_width - 1;
  localparam int unsigned GI_W = ram_address_width - 2;

  // Largest group count that fits in the BRAM depth.
  localparam logic [NG_W-1:0] GROUPS_MAX = NG_W'(2 ** GI_W);

  // Last WAIT count before LATCH; unused when the BRAM has single-cycle latency.
  localparam logic [1:0] WAIT_LAST = (bram_latency > 1) ? 2'(bram_latency - 2) : 2'd0;

  localparam logic [2:0] CTRL_HOLD  = 3'd0;
  localparam logic [2:0] CTRL_CLEAR = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_READ,
    ST_WAIT,
    ST_LATCH,
    ST_SETTLE,
    ST_PRESENT,
    ST_ABORT,
    ST_DONE
  } state_t;

  state_t          state;
  logic [GI_W-1:0] group;
  logic [1:0]      lane;
  logic [NG_W-1:0] n_groups;
  logic [1:0]      wait_cnt;

  logic [NG_W-1:0] n_start;
  logic            last_group;
  logic [2:0]      lane_ctrl;

  // Clamp the requested group count to the BRAM depth.
  always_comb begin
    n_start    = (num_groups > GROUPS_MAX) ? GROUPS_MAX : num_groups;
    last_group = ((NG_W'(group) + NG_W'(1)) == n_groups);
    lane_ctrl  = 3'(lane) + 3'd1;
  end

  // Sequencer FSM; every output is a register updated on entry to its state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      group            <= '0;
      lane             <= '0;
      n_groups         <= '0;
      wait_cnt         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      addr_bram_enable <= 1'b0;
      ram_address      <= '0;
      arbiter_ctrl     <= CTRL_HOLD;
      group_valid      <= 1'b0;
      group_index      <= '0;
    end else begin
      done         <= 1'b0;
      arbiter_ctrl <= CTRL_HOLD;
`ifdef IA_SEQ_ABORT_EN
      // Abort overrides everything in flight, including a same-cycle transfer.
      if (abort && (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ABORT)) begin
        state            <= ST_ABORT;
        addr_bram_enable <= 1'b0;
        group_valid      <= 1'b0;
        arbiter_ctrl     <= CTRL_CLEAR;
      end else
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            n_groups <= n_start;
            group    <= '0;
            lane     <= '0;
            if (n_start == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              arbiter_ctrl <= CTRL_CLEAR;
              state        <= ST_CLEAR;
            end
          end
        end

        ST_CLEAR: begin
          addr_bram_enable <= 1'b1;
          ram_address      <= {group, lane};
          state            <= ST_READ;
        end

        ST_READ: begin
          if (bram_latency > 1) begin
            wait_cnt <= 2'd0;
            state    <= ST_WAIT;
          end else begin
            arbiter_ctrl <= lane_ctrl;
            state        <= ST_LATCH;
          end
        end

        // Address and enable held while the BRAM read is in flight.
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            arbiter_ctrl <= lane_ctrl;
            state        <= ST_LATCH;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        ST_LATCH: begin
          if (lane != 2'd3) begin
            lane        <= lane + 2'd1;
            ram_address <= {group, lane + 2'd1};
            state       <= ST_READ;
          end else begin
            addr_bram_enable <= 1'b0;
            state            <= ST_SETTLE;
          end
        end

        // One idle cycle so the arbiter output registers pick up lane 4.
        ST_SETTLE: begin
          group_valid <= 1'b1;
          group_index <= group;
          state       <= ST_PRESENT;
        end

        ST_PRESENT: begin
          if (group_ready) begin
            group_valid <= 1'b0;
            if (last_group) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              group        <= group + GI_W'(1);
              lane         <= '0;
              arbiter_ctrl <= CTRL_CLEAR;
              state        <= ST_CLEAR;
            end
          end
        end

        ST_ABORT: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ia_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ia_addr_sequencer
// Self-checking bench for ia_addr_sequencer. The reference model describes a
// pass as a timeline: each group is a CLEAR cycle, four READ/latency slots,
// one SETTLE cycle and a PRESENT phase that lasts until ready is seen.
// Expected outputs are derived from the group number and the cycle offset
// within that timeline.
// ---------------------------------------------------------------------------
module tb_ia_addr_sequencer;

  localparam int AW         = 5;
  localparam int L          = 1;
  localparam int GROUPS_MAX = (2 ** AW) / 4;
  localparam int PER        = 1 + L;          // cycles per word: READ + latency
  localparam int SETTLE_OFF = 4 * PER + 1;
  localparam int GROUP_CYC  = 4 * PER + 3;    // CLEAR..PRESENT with immediate ready

  logic              clock;
  logic              reset;
  logic              start;
  logic [AW-2:0]     num_groups;
  logic              busy;
  logic              done;
  logic              addr_bram_enable;
  logic [AW-1:0]     ram_address;
  logic [2:0]        arbiter_ctrl;
  logic              group_valid;
  logic              group_ready;
  logic              abort;
  logic [AW-3:0]     group_index;

  int checks = 0;
  int errors = 0;

  ia_addr_sequencer #(
    .ram_address_width (AW),
    .bram_latency      (L)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .num_groups       (num_groups),
    .busy             (busy),
    .done             (done),
    .addr_bram_enable (addr_bram_enable),
    .ram_address      (ram_address),
    .arbiter_ctrl     (arbiter_ctrl),
    .group_valid      (group_valid),
    .group_ready      (group_ready),
`ifdef IA_SEQ_ABORT_EN
    .abort            (abort),
`endif
    .group_index      (group_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Checks that every output sits at its reset/idle value.
  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, addr_bram_enable, ram_address, arbiter_ctrl, group_valid, group_index} !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b en=%b addr=%0d ctrl=%0d valid=%b idx=%0d, all required 0",
               name, busy, done, addr_bram_enable, ram_address, arbiter_ctrl, group_valid, group_index);
    end
  endtask

  // Runs one pass against the timeline model.
  // mode: 0 ready always 1, 1 random ready, 2 ready only after 10 PRESENT cycles.
  // noise: drive stray start pulses with random num_groups while busy.
  // ab_grp/ab_off: assert abort when the model reaches that group/offset (-1 = never).
  task automatic run_pass(input string name, input int n_req, input int mode, input bit noise,
                          input int ab_grp, input int ab_off,
                          output int done_cyc, output int xfers, output int max_addr);
    int  n, g, o, c, pres_cnt, phase, k, p;
    bit  e_busy, e_done, e_en, e_valid, rdy, ab, present;
    logic [2:0] e_ctrl;
    int  e_addr;
    n        = (n_req > GROUPS_MAX) ? GROUPS_MAX : n_req;
    g        = 0;
    o        = 0;
    c        = 0;
    pres_cnt = 0;
    xfers    = 0;
    max_addr = -1;
    done_cyc = -1;
    phase    = (n == 0) ? 2 : 0;   // 0 running, 1 abort cycle, 2 done cycle, 3 idle
    @(negedge clock);
    start       = 1'b1;
    num_groups  = (AW-1)'(n_req);
    group_ready = 1'b0;
    abort       = 1'b0;
    forever begin
      @(negedge clock);
      c++;
      e_busy  = 1'b1;
      e_done  = 1'b0;
      e_en    = 1'b0;
      e_valid = 1'b0;
      e_ctrl  = 3'd0;
      e_addr  = 0;
      case (phase)
        0: begin
          if (o == 0) e_ctrl = 3'd7;
          else if (o <= 4 * PER) begin
            k      = (o - 1) / PER;
            p      = (o - 1) % PER;
            e_en   = 1'b1;
            e_addr = 4 * g + k;
            if (p == L) e_ctrl = 3'(k + 1);
          end else if (o > SETTLE_OFF) e_valid = 1'b1;
        end
        1:       e_ctrl = 3'd7;
        2:       e_done = 1'b1;
        default: e_busy = 1'b0;
      endcase

      checks++;
      if ({busy, done, addr_bram_enable, arbiter_ctrl, group_valid} !==
          {e_busy, e_done, e_en, e_ctrl, e_valid} ||
          (e_en && ram_address !== AW'(e_addr)) ||
          (e_valid && group_index !== (AW-2)'(g))) begin
        errors++;
        $display("FAIL %s cyc=%0d: got busy=%b done=%b en=%b addr=%0d ctrl=%0d valid=%b idx=%0d; expected busy=%b done=%b en=%b addr=%0d ctrl=%0d valid=%b idx=%0d",
                 name, c, busy, done, addr_bram_enable, ram_address, arbiter_ctrl, group_valid,
                 group_index, e_busy, e_done, e_en, e_addr, e_ctrl, e_valid, g);
      end
      if (addr_bram_enable && int'(ram_address) > max_addr) max_addr = int'(ram_address);
      if (done) done_cyc = c;
      if (phase == 3) break;

      present = (phase == 0) && (o > SETTLE_OFF);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 99) < 60);
        default: rdy = present && (pres_cnt >= 10);
      endcase
      ab          = (phase == 0) && (g == ab_grp) && (o == ab_off);
      group_ready = rdy;
      abort       = ab;
      start       = noise && ($urandom_range(0, 3) == 0);
      num_groups  = (AW-1)'($urandom);
      if (group_valid && rdy && !ab) xfers++;

      if (ab) phase = 1;
      else begin
        case (phase)
          0: begin
            if (present) begin
              if (rdy) begin
                pres_cnt = 0;
                if (g + 1 == n) phase = 2;
                else begin
                  g++;
                  o = 0;
                end
              end else pres_cnt++;
            end else o++;
          end
          1:       phase = 2;
          default: phase = 3;
        endcase
      end

      if (c > 3000) begin
        checks++;
        errors++;
        $display("FAIL %s: pass did not complete within 3000 cycles", name);
        break;
      end
    end
    start       = 1'b0;
    group_ready = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic test_reset;
    check_all_zero("reset_held");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset_released_idle");
  endtask

  task automatic test_two_groups;
    int dc, x, m;
    run_pass("two_groups", 2, 0, 1'b0, -1, -1, dc, x, m);
    check_int("two_groups_done_cycle", dc, 2 * GROUP_CYC + 1);
    check_int("two_groups_xfers", x, 2);
    check_int("two_groups_max_addr", m, 7);
  endtask

  task automatic test_zero_groups;
    int dc, x, m;
    run_pass("zero_groups", 0, 0, 1'b0, -1, -1, dc, x, m);
    check_int("zero_groups_done_cycle", dc, 1);
    check_int("zero_groups_enable_never", m, -1);
  endtask

  task automatic test_clamp;
    int dc, x, m;
    run_pass("clamp", 15, 1, 1'b1, -1, -1, dc, x, m);
    check_int("clamp_xfers", x, GROUPS_MAX);
    check_int("clamp_max_addr", m, 4 * GROUPS_MAX - 1);
  endtask

  task automatic test_backpressure;
    int dc, x, m;
    run_pass("backpressure", 2, 2, 1'b1, -1, -1, dc, x, m);
    check_int("backpressure_xfers", x, 2);
    check_int("backpressure_max_addr", m, 7);
  endtask

  task automatic test_random;
    int dc, x, m, nr;
    for (int i = 0; i < 6; i++) begin
      nr = int'($urandom_range(0, 15));
      run_pass("random", nr, 1, 1'b1, -1, -1, dc, x, m);
      check_int("random_xfers", x, (nr > GROUPS_MAX) ? GROUPS_MAX : nr);
    end
  endtask

  task automatic test_reset_mid_present;
    int dc, x, m, i;
    @(negedge clock);
    start       = 1'b1;
    num_groups  = (AW-1)'(3);
    group_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    i = 0;
    while (!group_valid && i < 200) begin
      @(negedge clock);
      i++;
    end
    check_int("mid_present_reached", int'(group_valid), 1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_mid_present");
    @(negedge clock);
    reset = 1'b0;
    run_pass("after_reset", 2, 0, 1'b0, -1, -1, dc, x, m);
    check_int("after_reset_xfers", x, 2);
  endtask

`ifdef IA_SEQ_ABORT_EN
  task automatic test_abort;
    int dc, x, m;
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_all_zero("abort_in_idle_ignored");
    // abort two cycles into group 1
    run_pass("abort_group1", 3, 0, 1'b0, 1, 2, dc, x, m);
    check_int("abort_group1_done_cycle", dc, GROUP_CYC + 1 + 2 + 2);
    check_int("abort_group1_xfers", x, 1);
    // abort together with ready while group 0 is presented
    run_pass("abort_vs_ready", 2, 0, 1'b0, 0, SETTLE_OFF + 1, dc, x, m);
    check_int("abort_vs_ready_done_cycle", dc, GROUP_CYC + 2);
    check_int("abort_vs_ready_xfers", x, 0);
  endtask
`endif

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    num_groups  = '0;
    group_ready = 1'b0;
    abort       = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_two_groups();
    test_zero_groups();
    test_clamp();
    test_backpressure();
    test_reset_mid_present();
`ifdef IA_SEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
